// File: rtl/shift_sequencer_pkg.sv
// ============================================================================
// Module  : shift_sequencer_pkg
// Brief   : Shared microcode ALU opcode encoding used by the shift sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_sequencer_pkg;

    localparam int MC_ALUOp_t_BITS = 4;

    typedef enum logic [MC_ALUOp_t_BITS-1:0] {
        ALUOp_SELA = 4'd0,
        ALUOp_SHL  = 4'd1,
        ALUOp_SHR  = 4'd2,
        ALUOp_SAR  = 4'd3,
        ALUOp_ROL  = 4'd4,
        ALUOp_ROR  = 4'd5,
        ALUOp_RCL  = 4'd6,
        ALUOp_RCR  = 4'd7
    } MC_ALUOp_t;

    // Each ALU pass shifts/rotates by exactly one position.
    localparam logic [15:0] c_SHIFT_STEP = 16'd1;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module  : shift_sequencer
// Brief   : Iterates a single-bit shift/rotate on the shared ALU 'count' times.
//           Define SHIFT_COUNT_MASK_EN to limit the count to its low 5 bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [MC_ALUOp_t_BITS-1:0] op,
    input  logic                       is_8_bit,
    input  logic [15:0]                value,
    input  logic [7:0]                 count,
    input  logic [15:0]                flags_in,
    input  logic                       flush,
    output logic [15:0]                alu_a,
    output logic [15:0]                alu_b,
    output logic [MC_ALUOp_t_BITS-1:0] alu_op,
    output logic                       alu_is_8_bit,
    output logic [15:0]                alu_flags_in,
    input  logic [15:0]                alu_out,
    input  logic [15:0]                alu_flags_out,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                result,
    output logic [15:0]                flags_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef SHIFT_COUNT_MASK_EN
    localparam logic [7:0] c_COUNT_MASK = 8'h1F;
`else
    localparam logic [7:0] c_COUNT_MASK = 8'hFF;
`endif

    state_t                     r_state;
    state_t                     w_next_state;
    logic [15:0]                r_value;
    logic [15:0]                r_flags;
    logic [MC_ALUOp_t_BITS-1:0] r_op;
    logic                       r_is_8_bit;
    logic [7:0]                 r_remaining;
    logic [15:0]                r_result;
    logic [15:0]                r_flags_out;
    logic [7:0]                 w_eff_count;

    assign w_eff_count = count & c_COUNT_MASK;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (w_eff_count != 8'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (r_remaining == 8'd1) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        // Flush overrides any progression, including a start seen in IDLE.
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_value     <= 16'd0;
            r_flags     <= 16'd0;
            r_op        <= ALUOp_SELA;
            r_is_8_bit  <= 1'b0;
            r_remaining <= 8'd0;
            r_result    <= 16'd0;
            r_flags_out <= 16'd0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_value     <= value;
                        r_flags     <= flags_in;
                        r_op        <= op;
                        r_is_8_bit  <= is_8_bit;
                        r_remaining <= w_eff_count;
                        if (w_eff_count == 8'd0) begin
                            r_result    <= value;
                            r_flags_out <= flags_in;
                        end
                    end
                end
                S_RUN: begin
                    r_value     <= alu_out;
                    r_flags     <= alu_flags_out;
                    r_remaining <= r_remaining - 8'd1;
                    // Results are published on the last pass so they are visible in DONE.
                    if (r_remaining == 8'd1) begin
                        r_result    <= alu_out;
                        r_flags_out <= alu_flags_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_a        = 16'd0;
        alu_b        = 16'd0;
        alu_op       = ALUOp_SELA;
        alu_is_8_bit = 1'b0;
        alu_flags_in = 16'd0;
        if (r_state == S_RUN) begin
            alu_a        = r_value;
            alu_b        = c_SHIFT_STEP;
            alu_op       = r_op;
            alu_is_8_bit = r_is_8_bit;
            alu_flags_in = r_flags;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign flags_out = r_flags_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module  : tb_shift_sequencer
// Brief   : Self-checking bench with an ALU model and a transaction-level
//           reference; honours SHIFT_COUNT_MASK_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic                       clk;
    logic                       reset_n;
    logic                       start;
    logic [MC_ALUOp_t_BITS-1:0] op;
    logic                       is_8_bit;
    logic [15:0]                value;
    logic [7:0]                 count;
    logic [15:0]                flags_in;
    logic                       flush;
    logic [15:0]                alu_a;
    logic [15:0]                alu_b;
    logic [MC_ALUOp_t_BITS-1:0] alu_op;
    logic                       alu_is_8_bit;
    logic [15:0]                alu_flags_in;
    logic [15:0]                alu_out;
    logic [15:0]                alu_flags_out;
    logic                       busy;
    logic                       done;
    logic [15:0]                result;
    logic [15:0]                flags_out;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    shift_sequencer u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .is_8_bit     (is_8_bit),
        .value        (value),
        .count        (count),
        .flags_in     (flags_in),
        .flush        (flush),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_is_8_bit (alu_is_8_bit),
        .alu_flags_in (alu_flags_in),
        .alu_out      (alu_out),
        .alu_flags_out(alu_flags_out),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .flags_out    (flags_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-position shift/rotate; CF is flags bit 0, other flags pass through.
    function automatic logic [31:0] alu_f(input logic [MC_ALUOp_t_BITS-1:0] f_op,
                                          input logic [15:0] a, input logic is8,
                                          input logic [15:0] fin);
        int          w;
        logic [15:0] m, x, r, top, cin;
        logic        cf;
        w   = is8 ? 8 : 16;
        m   = is8 ? 16'h00FF : 16'hFFFF;
        x   = a & m;
        top = 16'(x[w-1]);
        cin = 16'(fin[0]);
        r   = x;
        cf  = fin[0];
        case (f_op)
            ALUOp_SHL: begin r = (x << 1) & m;              cf = top[0]; end
            ALUOp_SHR: begin r = x >> 1;                    cf = x[0];   end
            ALUOp_SAR: begin r = (x >> 1) | (top << (w-1)); cf = x[0];   end
            ALUOp_ROL: begin r = ((x << 1) | top) & m;      cf = top[0]; end
            ALUOp_ROR: begin r = (x >> 1) | (16'(x[0]) << (w-1)); cf = x[0]; end
            ALUOp_RCL: begin r = ((x << 1) | cin) & m;      cf = top[0]; end
            ALUOp_RCR: begin r = (x >> 1) | (cin << (w-1)); cf = x[0];   end
            default: ;
        endcase
        if (is8) r = {a[15:8], r[7:0]};
        return {fin[15:1], cf, r};
    endfunction

    always_comb begin
        {alu_flags_out, alu_out} = alu_f(alu_op, alu_a, alu_is_8_bit, alu_flags_in);
    end

    function automatic int eff_count(input logic [7:0] c);
`ifdef SHIFT_COUNT_MASK_EN
        return int'(c) % 32;
`else
        return int'(c);
`endif
    endfunction

    // Transaction model: an accepted start keeps the block busy for N+1 cycles,
    // the last of which is the done cycle carrying the N-times-iterated value.
    int                         m_left = 0;
    int                         m_n = 0;
    logic [MC_ALUOp_t_BITS-1:0] m_op = '0;
    logic                       m_is8 = 1'b0;
    logic [15:0]                m_result = 16'd0;
    logic [15:0]                m_flags = 16'd0;
    logic [15:0]                m_va [0:255];
    logic [15:0]                m_vf [0:255];

    always @(posedge clk) begin
        logic [31:0] t;
        if (!reset_n) begin
            m_left = 0; m_result = 16'd0; m_flags = 16'd0;
        end else if (flush) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (start) begin
            m_n = eff_count(count);
            m_op = op;
            m_is8 = is_8_bit;
            m_va[0] = value;
            m_vf[0] = flags_in;
            for (int i = 0; i < m_n; i++) begin
                t = alu_f(op, m_va[i], is_8_bit, m_vf[i]);
                m_va[i+1] = t[15:0];
                m_vf[i+1] = t[31:16];
            end
            m_left = m_n + 1;
        end
        if (reset_n && m_left == 1) begin
            m_result = m_va[m_n];
            m_flags  = m_vf[m_n];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int k;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_left == 1));
            check("result", 32'(result), 32'(m_result));
            check("flags_out", 32'(flags_out), 32'(m_flags));
            if (m_left > 1) begin
                k = m_n + 1 - m_left;
                check("alu_a", 32'(alu_a), 32'(m_va[k]));
                check("alu_flags_in", 32'(alu_flags_in), 32'(m_vf[k]));
                check("alu_b", 32'(alu_b), 32'd1);
                check("alu_op", 32'(alu_op), 32'(m_op));
                check("alu_is_8_bit", 32'(alu_is_8_bit), 32'(m_is8));
            end else begin
                check("alu_op_idle", 32'(alu_op), 32'(ALUOp_SELA));
                check("alu_a_idle", 32'(alu_a), 32'd0);
                check("alu_b_idle", 32'(alu_b), 32'd0);
                check("alu_flags_in_idle", 32'(alu_flags_in), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start in cycle 0, then find the done cycle and check hand-computed values.
    task automatic run_dir(input string name, input logic [MC_ALUOp_t_BITS-1:0] d_op,
                           input logic d_is8, input logic [15:0] d_val,
                           input logic [7:0] d_cnt, input logic [15:0] d_fin,
                           input int exp_cyc, input logic [15:0] exp_res,
                           input logic [15:0] res_mask, input logic [15:0] exp_fl,
                           input logic [15:0] fl_mask);
        int c;
        tick();
        start = 1'b1; op = d_op; is_8_bit = d_is8; value = d_val;
        count = d_cnt; flags_in = d_fin;
        @(negedge clk);
        tick();
        start = 1'b0;
        c = 1;
        while (c < 400) begin
            @(negedge clk);
            if (done) break;
            c++;
        end
        check({name, "_done_cycle"}, 32'(c), 32'(exp_cyc));
        check({name, "_result"}, 32'(result & res_mask), 32'(exp_res));
        check({name, "_flags"}, 32'(flags_out & fl_mask), 32'(exp_fl));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = ALUOp_SHL;
        is_8_bit = 1'b0; value = 16'd0; count = 8'd0; flags_in = 16'd0;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags_out), 32'd0);
        tick();
        reset_n = 1'b1;

`ifdef SHIFT_COUNT_MASK_EN
        run_dir("shl_cnt33", ALUOp_SHL, 1'b0, 16'hFFFF, 8'd33, 16'h0000,
                2, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000);
`else
        run_dir("shl_cnt33", ALUOp_SHL, 1'b0, 16'hFFFF, 8'd33, 16'h0000,
                34, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
`endif
        run_dir("shl3", ALUOp_SHL, 1'b0, 16'h0001, 8'd3, 16'h0000,
                4, 16'h0008, 16'hFFFF, 16'h0000, 16'h0001);
        run_dir("ror8", ALUOp_ROR, 1'b1, 16'h0081, 8'd1, 16'h0000,
                2, 16'h00C0, 16'h00FF, 16'h0001, 16'h0001);
        run_dir("cnt0", ALUOp_ROL, 1'b0, 16'h1234, 8'd0, 16'h0046,
                1, 16'h1234, 16'hFFFF, 16'h0046, 16'hFFFF);

        // Flush mid-run, with an ignored start attempt in cycle 2.
        tick();
        start = 1'b1; op = ALUOp_SHR; value = 16'h8000; count = 8'd10; flags_in = 16'h0;
        tick(); start = 1'b0;
        tick(); start = 1'b1; op = ALUOp_SHL; count = 8'd0;
        tick(); start = 1'b0;
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_result", 32'(result), 32'h1234);
        check("flush_flags", 32'(flags_out), 32'h0046);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("flush_no_done", 32'(done), 32'd0);
        end

        // Reset in cycle 3 of an 8-iteration run.
        tick();
        start = 1'b1; op = ALUOp_ROL; value = 16'h00F0; count = 8'd8;
        tick(); start = 1'b0;
        tick();
        tick(); reset_n = 1'b0;
        tick(); reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_flags", 32'(flags_out), 32'd0);
        run_dir("after_rst", ALUOp_SHL, 1'b0, 16'h0001, 8'd1, 16'h0000,
                2, 16'h0002, 16'hFFFF, 16'h0000, 16'hFFFF);

        for (int i = 0; i < 3000; i++) begin
            tick();
            reset_n  = ($urandom % 150) != 0;
            flush    = ($urandom % 60) == 0;
            start    = ($urandom % 3) == 0;
            op       = MC_ALUOp_t_BITS'($urandom_range(1, 7));
            is_8_bit = 1'($urandom % 2);
            value    = 16'($urandom);
            flags_in = 16'($urandom);
            count    = (($urandom % 20) == 0) ? 8'($urandom) : 8'($urandom % 6);
        end
        tick();
        reset_n = 1'b1; flush = 1'b0; start = 1'b0;
        repeat (300) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
